// File: rtl/usb_tx_sched.sv
// usb_tx_sched: USB transmit scheduler.
// Synchronises "page written" events from the mclk domain into usb_clk and
// queues the written pages. Pages go to the slave-FIFO controller one at a
// time, and the handshake page 0 is always sent before any data page.
// Optional feature macro: USB_TX_SCHED_STATS_EN enables the live sent_cnt and
// drop_cnt counters. Without it both outputs are tied to zero.
module usb_tx_sched #(
    parameter int BADDR_NBIT  = 3,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  usb_clk,
    input  logic                  rst,
    input  logic                  wr_eop,
    input  logic [BADDR_NBIT-1:0] wr_baddr,
    input  logic                  f_full,
    input  logic                  tx_done,
    output logic                  tx_sop,
    output logic [BADDR_NBIT-1:0] tx_baddr,
    output logic                  busy,
    output logic                  ovf,
    output logic                  tmo,
    input  logic                  clr_err,
    output logic [15:0]           sent_cnt,
    output logic [15:0]           drop_cnt
);

    localparam logic [BADDR_NBIT-1:0] PAGE_MAX   = '1;
    localparam logic [BADDR_NBIT-1:0] PAGE_FIRST = BADDR_NBIT'(1);
    localparam int                    WD_W       = $clog2(TIMEOUT_CYC) + 1;
    localparam int                    GAP_W      = $clog2(GAP_CYC) + 1;
    localparam logic [WD_W-1:0]       WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_BUSY,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              p_eop_q;
    logic                    ev_q;
    logic [BADDR_NBIT-1:0]   ev_baddr_q;
    logic                    hs_pend_q, hs_pend_d;
    logic [BADDR_NBIT-1:0]   pend_cnt_q, pend_cnt_d;
    logic [BADDR_NBIT-1:0]   rd_page_q, rd_page_d;
    logic [BADDR_NBIT-1:0]   tx_baddr_q, tx_baddr_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    ovf_q, ovf_d;
    logic                    tmo_q, tmo_d;

    logic                    ev_hs;
    logic                    ev_data;
    logic                    consume_hs;
    logic                    consume_data;
    logic                    drop_page;
    logic                    tmo_fire;

    assign ev_hs        = ev_q && (ev_baddr_q == '0);
    assign ev_data      = ev_q && (ev_baddr_q != '0);
    assign consume_hs   = (state_q == S_ARM) && (tx_baddr_q == '0);
    assign consume_data = (state_q == S_ARM) && (tx_baddr_q != '0);
    assign drop_page    = ev_data && !consume_data && (pend_cnt_q == PAGE_MAX);
    assign tmo_fire     = (state_q == S_BUSY) && !tx_done && (wd_q == WD_LAST);

    assign tx_sop   = (state_q == S_ARM);
    assign busy     = (state_q != S_IDLE);
    assign tx_baddr = tx_baddr_q;
    assign ovf      = ovf_q;
    assign tmo      = tmo_q;

    // Synchronise wr_eop and register the rising-edge event with its page index
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            p_eop_q    <= '0;
            ev_q       <= 1'b0;
            ev_baddr_q <= '0;
        end else begin
            p_eop_q <= {p_eop_q[1:0], wr_eop};
            ev_q    <= (p_eop_q[2:1] == 2'b01);
            if (p_eop_q[2:1] == 2'b01) begin
                ev_baddr_q <= wr_baddr;
            end
        end
    end

    // Pending-work bookkeeping: handshake flag, data page count, rotation pointer, error flags
    always_comb begin
        hs_pend_d  = hs_pend_q;
        pend_cnt_d = pend_cnt_q;
        rd_page_d  = rd_page_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;

        if (consume_hs) begin
            hs_pend_d = 1'b0;
        end
        if (ev_hs) begin
            hs_pend_d = 1'b1;
        end

        case ({ev_data, consume_data})
            2'b10: begin
                if (pend_cnt_q != PAGE_MAX) begin
                    pend_cnt_d = pend_cnt_q + PAGE_FIRST;
                end
            end
            2'b01: pend_cnt_d = pend_cnt_q - PAGE_FIRST;
            default: pend_cnt_d = pend_cnt_q;
        endcase

        if (consume_data) begin
            rd_page_d = (rd_page_q == PAGE_MAX) ? PAGE_FIRST : rd_page_q + PAGE_FIRST;
        end

        if (clr_err) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (drop_page) begin
            ovf_d = 1'b1;
        end
        if (tmo_fire) begin
            tmo_d = 1'b1;
        end
    end

    // Dispatch FSM next state: pick a page, hold it through BUSY, then idle out the gap
    always_comb begin
        state_d    = state_q;
        tx_baddr_d = tx_baddr_q;
        wd_d       = wd_q;
        gap_d      = gap_q;

        case (state_q)
            S_IDLE: begin
                if (hs_pend_q) begin
                    state_d    = S_ARM;
                    tx_baddr_d = '0;
                end else if ((pend_cnt_q != '0) && !f_full) begin
                    state_d    = S_ARM;
                    tx_baddr_d = rd_page_q;
                end
            end
            S_ARM: begin
                state_d = S_BUSY;
                wd_d    = '0;
            end
            S_BUSY: begin
                if (tx_done || (wd_q == WD_LAST)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and queue registers; reset drops anything in flight or queued
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_baddr_q <= '0;
            wd_q       <= '0;
            gap_q      <= '0;
            hs_pend_q  <= 1'b0;
            pend_cnt_q <= '0;
            rd_page_q  <= PAGE_FIRST;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_baddr_q <= tx_baddr_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
            hs_pend_q  <= hs_pend_d;
            pend_cnt_q <= pend_cnt_d;
            rd_page_q  <= rd_page_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef USB_TX_SCHED_STATS_EN
    logic [15:0] sent_q;
    logic [15:0] drop_q;
    logic        sent_inc;

    assign sent_inc = (state_q == S_BUSY) && tx_done;

    // Statistics counters; an event landing with clr_err still counts once
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            sent_q <= '0;
            drop_q <= '0;
        end else if (clr_err) begin
            sent_q <= {15'b0, sent_inc};
            drop_q <= {15'b0, drop_page};
        end else begin
            if (sent_inc) begin
                sent_q <= sent_q + 16'd1;
            end
            if (drop_page) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign sent_cnt = sent_q;
    assign drop_cnt = drop_q;
`else
    assign sent_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: scoreboard bench for usb_tx_sched with randomised batches.
// Expected dispatch pages are queued by the stimulus side from a transaction
// model (pending handshake, pending data count, rotation pointer); a monitor
// pops and compares on every tx_sop.
module tb_usb_tx_sched;

    localparam int BADDR_NBIT  = 3;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 128;
    localparam int NPAGE       = 7;

    logic                  usb_clk = 1'b0;
    logic                  rst;
    logic                  wr_eop;
    logic [BADDR_NBIT-1:0] wr_baddr;
    logic                  f_full;
    logic                  tx_done;
    logic                  tx_sop;
    logic [BADDR_NBIT-1:0] tx_baddr;
    logic                  busy;
    logic                  ovf;
    logic                  tmo;
    logic                  clr_err;
    logic [15:0]           sent_cnt;
    logic [15:0]           drop_cnt;

    usb_tx_sched #(
        .BADDR_NBIT (BADDR_NBIT),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .usb_clk (usb_clk),
        .rst     (rst),
        .wr_eop  (wr_eop),
        .wr_baddr(wr_baddr),
        .f_full  (f_full),
        .tx_done (tx_done),
        .tx_sop  (tx_sop),
        .tx_baddr(tx_baddr),
        .busy    (busy),
        .ovf     (ovf),
        .tmo     (tmo),
        .clr_err (clr_err),
        .sent_cnt(sent_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 usb_clk = ~usb_clk;

    int tests    = 0;
    int fails    = 0;
    int sopCount = 0;
    int expQ[$];
    int batchEv[$];

    bit mHs;
    int mPend;
    int mNext;
    int mSent;
    int mDrop;
    bit mOvf;
    bit mTmo;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    function automatic int expCnt(input int v);
`ifdef USB_TX_SCHED_STATS_EN
        return v & 16'hFFFF;
`else
        return (v & 0);
`endif
    endfunction

    // Monitor: every start-of-packet must match the oldest expected page
    always @(negedge usb_clk) begin
        if (!rst && tx_sop) begin
            sopCount++;
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_sop: got page %0d, expected no dispatch", tx_baddr);
            end else begin
                checkOutput("tx_baddr", int'(tx_baddr), expQ.pop_front());
            end
        end
    end

    task automatic modelReset();
        mHs   = 1'b0;
        mPend = 0;
        mNext = 1;
        mSent = 0;
        mDrop = 0;
        mOvf  = 1'b0;
        mTmo  = 1'b0;
        expQ.delete();
    endtask

    task automatic modelEvent(input int b);
        if (b == 0) begin
            mHs = 1'b1;
        end else if (mPend == NPAGE) begin
            mDrop++;
            mOvf = 1'b1;
        end else begin
            mPend++;
        end
    endtask

    // Turn everything pending into expected dispatches: handshake first, then rotation order
    task automatic modelPushAll(input bit dataAllowed, output int pushed);
        pushed = 0;
        if (mHs) begin
            expQ.push_back(0);
            mHs = 1'b0;
            pushed++;
        end
        if (dataAllowed) begin
            while (mPend > 0) begin
                expQ.push_back(mNext);
                mNext = (mNext % NPAGE) + 1;
                mPend--;
                pushed++;
            end
        end
    endtask

    task automatic applyStimulus(input int b);
        @(posedge usb_clk);
        #1;
        wr_eop   = 1'b1;
        wr_baddr = BADDR_NBIT'(b);
        repeat (3) @(posedge usb_clk);
        #1;
        wr_eop = 1'b0;
        repeat (2) @(posedge usb_clk);
        modelEvent(b);
    endtask

    task automatic waitSop(input int limit, input string name);
        int start;
        int n;
        start = sopCount;
        n     = 0;
        while (sopCount == start && n < limit) begin
            @(posedge usb_clk);
            n++;
        end
        if (sopCount == start) begin
            failTimeout(name);
        end
    endtask

    task automatic pulseDone();
        @(posedge usb_clk);
        #1;
        tx_done = 1'b1;
        @(posedge usb_clk);
        #1;
        tx_done = 1'b0;
    endtask

    task automatic completePacket(input int delay);
        repeat (delay) @(posedge usb_clk);
        pulseDone();
        mSent++;
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n;
        n = 0;
        @(negedge usb_clk);
        while (busy && n < limit) begin
            @(negedge usb_clk);
            n++;
        end
        if (busy) begin
            failTimeout(name);
        end
    endtask

    task automatic checkStatus(input string tag);
        @(negedge usb_clk);
        checkOutput({tag, "_ovf"}, int'(ovf), int'(mOvf));
        checkOutput({tag, "_tmo"}, int'(tmo), int'(mTmo));
        checkOutput({tag, "_sent_cnt"}, int'(sent_cnt), expCnt(mSent));
        checkOutput({tag, "_drop_cnt"}, int'(drop_cnt), expCnt(mDrop));
    endtask

    task automatic pulseClear();
        @(posedge usb_clk);
        #1;
        clr_err = 1'b1;
        @(posedge usb_clk);
        #1;
        clr_err = 1'b0;
        mOvf  = 1'b0;
        mTmo  = 1'b0;
        mSent = 0;
        mDrop = 0;
    endtask

    // Primer packet, then batchEv issued while it is BUSY, then drain everything
    task automatic runBatch(input int primer, input string tag);
        int k;
        int dummy;
        applyStimulus(primer);
        modelPushAll(1'b1, dummy);
        waitSop(20, {tag, "_primer_sop"});
        foreach (batchEv[i]) begin
            applyStimulus(batchEv[i]);
        end
        repeat (2) @(posedge usb_clk);
        modelPushAll(1'b1, k);
        completePacket($urandom_range(1, 20));
        for (int i = 0; i < k; i++) begin
            waitSop(GAP_CYC + 20, {tag, "_sop"});
            completePacket($urandom_range(1, 20));
        end
        waitIdle(50, {tag, "_idle"});
        checkStatus(tag);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_sop"}, int'(tx_sop), 0);
        checkOutput({tag, "_tx_baddr"}, int'(tx_baddr), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_ovf"}, int'(ovf), 0);
        checkOutput({tag, "_tmo"}, int'(tmo), 0);
        checkOutput({tag, "_sent_cnt"}, int'(sent_cnt), 0);
        checkOutput({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int k;
        int start;
        int n;

        rst      = 1'b1;
        wr_eop   = 1'b0;
        wr_baddr = '0;
        f_full   = 1'b0;
        tx_done  = 1'b0;
        clr_err  = 1'b0;
        modelReset();

        repeat (3) @(posedge usb_clk);
        @(negedge usb_clk);
        checkResetOutputs("reset");
        @(posedge usb_clk);
        #1;
        rst = 1'b0;

        // Event latency and rotation: input page 2 is sent as page 1
        modelEvent(2);
        modelPushAll(1'b1, k);
        @(posedge usb_clk);
        #1;
        wr_eop   = 1'b1;
        wr_baddr = 3'd2;
        repeat (3) @(posedge usb_clk);
        #1;
        wr_eop = 1'b0;
        @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("sop_not_early", int'(tx_sop), 0);
        @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("sop_latency", int'(tx_sop), 1);
        repeat (9) @(posedge usb_clk);
        #1;
        tx_done = 1'b1;
        mSent++;
        @(posedge usb_clk);
        #1;
        tx_done = 1'b0;
        repeat (GAP_CYC - 1) @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("busy_in_gap", int'(busy), 1);
        @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("busy_after_gap", int'(busy), 0);
        checkStatus("latency");

        // Handshake queued behind three data pages still goes first
        batchEv.delete();
        batchEv.push_back(3);
        batchEv.push_back(6);
        batchEv.push_back(1);
        batchEv.push_back(0);
        runBatch(5, "priority");

        // Endpoint full holds data but not the handshake
        @(posedge usb_clk);
        #1;
        f_full = 1'b1;
        applyStimulus(1);
        applyStimulus(4);
        start = sopCount;
        repeat (100) @(posedge usb_clk);
        checkOutput("no_sop_while_full", sopCount - start, 0);
        applyStimulus(0);
        modelPushAll(1'b0, k);
        waitSop(10, "hs_while_full");
        completePacket(3);
        waitIdle(50, "hs_idle");
        @(posedge usb_clk);
        #1;
        f_full = 1'b0;
        modelPushAll(1'b1, k);
        waitSop(2, "resume_after_full");
        completePacket(4);
        waitSop(GAP_CYC + 5, "resume_second");
        completePacket(4);
        waitIdle(50, "resume_idle");
        checkStatus("full");

        // Eight data pages with nowhere to go: seven kept, one dropped
        @(posedge usb_clk);
        #1;
        f_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom_range(1, NPAGE));
        end
        checkStatus("overflow");
        pulseClear();
        checkStatus("overflow_clr");
        @(posedge usb_clk);
        #1;
        f_full = 1'b0;
        modelPushAll(1'b1, k);
        checkOutput("overflow_kept", k, 7);
        for (int i = 0; i < k; i++) begin
            waitSop(GAP_CYC + 10, "overflow_drain");
            completePacket($urandom_range(1, 5));
        end
        waitIdle(50, "overflow_idle");
        checkStatus("drain");

        // Watchdog expires on BUSY cycle TIMEOUT_CYC; the next page still goes out
        applyStimulus($urandom_range(1, NPAGE));
        modelPushAll(1'b1, k);
        waitSop(10, "tmo_sop");
        repeat (TIMEOUT_CYC - 1) @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("tmo_not_early", int'(tmo), 0);
        @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("tmo_expire", int'(tmo), 1);
        mTmo = 1'b1;
        applyStimulus($urandom_range(1, NPAGE));
        modelPushAll(1'b1, k);
        waitSop(10, "after_tmo_sop");
        completePacket(2);
        waitIdle(50, "after_tmo_idle");
        checkStatus("timeout");
        pulseClear();
        checkStatus("timeout_clr");

        // Random batches of data events with an optional handshake mixed in
        for (int b = 0; b < 6; b++) begin
            batchEv.delete();
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                batchEv.push_back($urandom_range(1, NPAGE));
            end
            if ($urandom_range(0, 1) == 1) begin
                batchEv.insert($urandom_range(0, n), 0);
            end
            runBatch($urandom_range(1, NPAGE), "random");
        end

        // Reset during BUSY aborts at once; a late tx_done is ignored
        applyStimulus(3);
        modelPushAll(1'b1, k);
        waitSop(10, "rst_sop");
        repeat (5) @(posedge usb_clk);
        #3;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        modelReset();
        @(posedge usb_clk);
        #1;
        rst = 1'b0;
        start = sopCount;
        pulseDone();
        repeat (10) @(posedge usb_clk);
        @(negedge usb_clk);
        checkOutput("late_done_busy", int'(busy), 0);
        checkOutput("late_done_sent", int'(sent_cnt), 0);
        checkOutput("late_done_no_sop", sopCount - start, 0);
        applyStimulus(6);
        modelPushAll(1'b1, k);
        waitSop(10, "post_reset_sop");
        completePacket(3);
        waitIdle(50, "post_reset_idle");
        checkStatus("post_reset");
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
